// File: rtl/ndata_serializer.sv
// ---------------------------------------------------------------------------
// ndata_serializer
//
// Turns a wide stream (NUM_ELEMENTS lanes per beat, per-lane keep, beat-level
// last) into a narrow stream with one element per beat. One wide beat is held
// at a time. Its kept lanes are emitted in ascending lane order, one per
// cycle, and gaps in keep are skipped with no idle cycles. A beat with no kept
// lanes still produces one output beat (keep=0) so packet framing survives.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-high
//   in_data    NUM_ELEMENTS x $bits(data_t) wide input lanes
//   in_keep    per-lane keep of the wide beat
//   in_last    end-of-packet marker of the wide beat
//   in_valid   wide beat present
//   in_ready   wide beat can be taken (combinational from out_ready)
//   out_data   current element
//   out_keep   1 when out_data carries a real element
//   out_last   end of packet (set only on the beat's final element)
//   out_valid  output element present
//   out_ready  consumer takes the output element
// ---------------------------------------------------------------------------
module ndata_serializer #(
   parameter type data_t       = logic [31:0],
   parameter int  NUM_ELEMENTS = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [NUM_ELEMENTS-1:0][$bits(data_t)-1:0]  in_data,
   input  logic [NUM_ELEMENTS-1:0]                     in_keep,
   input  logic                                        in_last,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   output logic [$bits(data_t)-1:0]                    out_data,
   output logic                                        out_keep,
   output logic                                        out_last,
   output logic                                        out_valid,
   input  logic                                        out_ready
);

   localparam int DW = $bits(data_t);

   // Held wide beat and the mask of lanes still to be emitted.
   logic [NUM_ELEMENTS-1:0][DW-1:0] hold_data_reg;
   logic [NUM_ELEMENTS-1:0]         rem_reg;
   logic                            hold_last_reg;
   logic                            hold_valid_reg;

   logic [NUM_ELEMENTS-1:0]         sel_onehot;
   logic [NUM_ELEMENTS-1:0]         rem_after_pop;
   logic [NUM_ELEMENTS-1:0][DW-1:0] lane_masked;
   logic [DW-1:0]                   sel_data;
   logic                            final_elem;
   logic                            accept;
   logic                            pop;

   // Two's-complement trick isolates the lowest set bit of rem: that is the
   // lane currently presented. Removing it leaves the lanes still to come,
   // so "nothing left after this one" is exactly popcount(rem) <= 1.
   assign sel_onehot    = rem_reg & (-rem_reg);
   assign rem_after_pop = rem_reg & ~sel_onehot;
   assign final_elem    = (rem_after_pop == '0);

   // One-hot AND-OR lane mux; yields zero when no lane is left.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane_mask
         assign lane_masked[gi] = sel_onehot[gi] ? hold_data_reg[gi] : '0;
      end
   endgenerate

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         sel_data = sel_data | lane_masked[i];
      end
   end

   assign out_valid = hold_valid_reg;
   assign out_data  = sel_data;
   assign out_keep  = (rem_reg != '0);
   assign out_last  = hold_last_reg && final_elem;

   // A new beat may enter while the held beat's final element is leaving,
   // which gives back-to-back beats without a bubble.
   assign in_ready = !rst && (!hold_valid_reg || (out_ready && final_elem));
   assign accept   = in_valid && in_ready;
   assign pop      = hold_valid_reg && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_reg <= 1'b0;
         rem_reg        <= '0;
         hold_last_reg  <= 1'b0;
      end else if (accept) begin
         hold_valid_reg <= 1'b1;
         rem_reg        <= in_keep;
         hold_last_reg  <= in_last;
      end else if (pop) begin
         if (final_elem) begin
            hold_valid_reg <= 1'b0;
         end
         rem_reg <= rem_after_pop;
      end
   end

   // Lane data needs no reset: it is only observed while hold_valid_reg is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_data_reg <= in_data;
      end
   end

endmodule

// File: tb/tb_ndata_serializer.sv
// ---------------------------------------------------------------------------
// tb_ndata_serializer
//
// Self-checking bench for ndata_serializer. A queue model expands every
// accepted wide beat into the element sequence it must produce; a compare
// process checks the DUT against the queue head on every falling edge.
// Directed tests additionally pin exact sequences and cycle offsets with
// hand-computed literals taken from the captured output stream.
// ---------------------------------------------------------------------------
module tb_ndata_serializer;

   localparam int N = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [N-1:0][31:0]  in_data = '0;
   logic [N-1:0]        in_keep = '0;
   logic                in_last = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [31:0]         out_data;
   logic                out_keep;
   logic                out_last;
   logic                out_valid;
   logic                out_ready = 1'b0;

   always #5 clk = ~clk;

   ndata_serializer #(
      .data_t       (logic [31:0]),
      .NUM_ELEMENTS (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        keep;
      logic        last;
   } elem_t;

   typedef struct {
      logic [31:0] data;
      logic        keep;
      logic        last;
      int          cyc;
      logic        inr;
   } cap_t;

   elem_t model_q[$];   // elements the DUT still owes
   cap_t  cap_q[$];     // elements the DUT actually delivered
   int    acc_q[$];     // cycle numbers of accepted wide beats
   int    checks   = 0;
   int    failures = 0;
   int    cycle    = 0;
   bit    rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Expand a wide beat into its element sequence: kept lanes in ascending
   // order, last only on the final one; an empty beat still yields one beat.
   function automatic void model_push(input logic [N-1:0][31:0] d,
                                      input logic [N-1:0] k, input logic l);
      int nk;
      int seen;
      nk   = $countones(k);
      seen = 0;
      if (nk == 0) model_q.push_back('{32'h0, 1'b0, l});
      for (int i = 0; i < N; i++) begin
         if (k[i]) begin
            seen++;
            model_q.push_back('{d[i], 1'b1, l && (seen == nk)});
         end
      end
   endfunction

   // Compare process: inputs change only just after rising edges, so the
   // falling edge sees settled values and the handshakes of the next edge.
   always @(negedge clk) begin
      cycle++;
      if (rst) begin
         model_q.delete();
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
      end else begin
         check("out_valid", out_valid, model_q.size() != 0);
         check("in_ready", in_ready,
               (model_q.size() == 0) || (model_q.size() == 1 && out_ready));
         if (out_valid && model_q.size() != 0) begin
            check("out_keep", out_keep, model_q[0].keep);
            check("out_last", out_last, model_q[0].last);
            if (model_q[0].keep) check("out_data", out_data, model_q[0].data);
         end
         if (out_valid && out_ready) begin
            cap_q.push_back('{out_data, out_keep, out_last, cycle, in_ready});
            if (model_q.size() != 0) void'(model_q.pop_front());
         end
         if (in_valid && in_ready) begin
            $display("beat cycle=%0d keep=%02h last=%0b lane0=%08h",
                     cycle, in_keep, in_last, in_data[0]);
            acc_q.push_back(cycle);
            model_push(in_data, in_keep, in_last);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Present a beat from just after a rising edge until it is taken.
   task automatic send_beat(input logic [N-1:0][31:0] d, input logic [N-1:0] k,
                            input logic l);
      int waited;
      waited   = 0;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready) begin
         waited++;
         if (waited > 200) begin
            check("send_timeout", 1, 0);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (model_q.size() != 0 || out_valid) begin
         n++;
         if (n > 2000) begin
            check("idle_timeout", 1, 0);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      cap_q.delete();
      acc_q.delete();
   endtask

   initial begin
      logic [N-1:0][31:0] d;
      logic [N-1:0]       k;
      int                 exp_total;
      int                 n_last;

      // ---- reset ----
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // ---- single full beat ----
      out_ready = 1'b1;
      clear_logs();
      for (int i = 0; i < N; i++) d[i] = 32'(10 + i);
      send_beat(d, 8'hFF, 1'b1);
      wait_idle();
      check("full_count", cap_q.size(), 8);
      if (cap_q.size() >= 8 && acc_q.size() >= 1) begin
         for (int i = 0; i < 8; i++) begin
            check("full_data", cap_q[i].data, 32'(10 + i));
            check("full_keep", cap_q[i].keep, 1);
            check("full_last", cap_q[i].last, (i == 7) ? 1 : 0);
            check("full_cycle", cap_q[i].cyc - acc_q[0], i + 1);
         end
         check("full_in_ready_7th", cap_q[6].inr, 0);
         check("full_in_ready_8th", cap_q[7].inr, 1);
      end

      // ---- sparse beat followed immediately by another ----
      clear_logs();
      for (int i = 0; i < N; i++) d[i] = 32'(i);
      send_beat(d, 8'b1010_0101, 1'b0);
      d[0] = 32'h55;
      send_beat(d, 8'h01, 1'b1);
      wait_idle();
      check("sparse_count", cap_q.size(), 5);
      if (cap_q.size() >= 5 && acc_q.size() >= 2) begin
         check("sparse_d0", cap_q[0].data, 0);
         check("sparse_d1", cap_q[1].data, 2);
         check("sparse_d2", cap_q[2].data, 5);
         check("sparse_d3", cap_q[3].data, 7);
         check("sparse_d4", cap_q[4].data, 32'h55);
         check("sparse_last3", cap_q[3].last, 0);
         check("sparse_last4", cap_q[4].last, 1);
         check("sparse_dense", cap_q[3].cyc - cap_q[0].cyc, 3);
         check("sparse_next_accept", acc_q[1], cap_q[3].cyc);
      end

      // ---- zero-keep beats ----
      clear_logs();
      d    = '0;
      send_beat(d, 8'h00, 1'b0);
      send_beat(d, 8'h00, 1'b1);
      d[0] = 32'hAA;
      send_beat(d, 8'h01, 1'b1);
      wait_idle();
      check("zero_count", cap_q.size(), 3);
      if (cap_q.size() >= 3) begin
         check("zero0_keep", cap_q[0].keep, 0);
         check("zero0_last", cap_q[0].last, 0);
         check("zero1_keep", cap_q[1].keep, 0);
         check("zero1_last", cap_q[1].last, 1);
         check("zero2_data", cap_q[2].data, 32'hAA);
         check("zero2_keep", cap_q[2].keep, 1);
         check("zero2_last", cap_q[2].last, 1);
      end

      // ---- stall on the final element ----
      clear_logs();
      d    = '0;
      d[0] = 32'h100;
      d[1] = 32'h101;
      send_beat(d, 8'h03, 1'b0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_data   = '0;
      in_data[0] = 32'h1B0;
      in_keep   = 8'h01;
      in_last   = 1'b1;
      in_valid  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_data", out_data, 32'h101);
         check("stall_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_idle();
      check("stall_count", cap_q.size(), 3);
      if (cap_q.size() >= 3 && acc_q.size() >= 2) begin
         check("stall_d1", cap_q[1].data, 32'h101);
         check("stall_d2", cap_q[2].data, 32'h1B0);
         check("stall_same_cycle", acc_q[1], cap_q[1].cyc);
      end

      // ---- back-to-back random beats under random backpressure ----
      clear_logs();
      exp_total  = 0;
      rand_ready = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int i = 0; i < N; i++) d[i] = $urandom;
         k = 8'($urandom);
         if (b % 10 == 0) k = '0;
         exp_total += (k == 0) ? 1 : $countones(k);
         send_beat(d, k, (b % 4) == 3);
      end
      wait_idle();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      n_last = 0;
      foreach (cap_q[i]) if (cap_q[i].last) n_last++;
      check("rand_total", cap_q.size(), exp_total);
      check("rand_lasts", n_last, 25);

      // ---- asynchronous reset mid-beat ----
      for (int i = 0; i < N; i++) d[i] = 32'(32'h200 + i);
      send_beat(d, 8'hFF, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_in_ready", in_ready, 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_idle", out_valid, 0);
      end
      @(posedge clk);
      #1;
      clear_logs();
      for (int i = 0; i < N; i++) d[i] = 32'(32'h300 + i);
      send_beat(d, 8'hFF, 1'b1);
      wait_idle();
      check("post_reset_count", cap_q.size(), 8);
      if (cap_q.size() >= 1 && acc_q.size() >= 1) begin
         check("post_reset_first", cap_q[0].data, 32'h300);
         check("post_reset_latency", cap_q[0].cyc - acc_q[0], 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
